// File: rtl/fibo_checker.sv
// Streaming Fibonacci monitor: checks each accepted term against the wrap-around
// sum of the two before it and reports match pulses, sticky error/wrap flags and a count.
module fibo_checker #(
    parameter int WIDTH      = 4,
    parameter int SEED_CHECK = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             match,
    output logic             error,
    output logic             locked,
    output logic             wrap_seen,
    output logic [WIDTH-1:0] expected,
    output logic [CNT_W-1:0] term_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ONE   = 2'd1,
        S_TRACK = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   prev1_q, prev1_d;
    logic [WIDTH-1:0]   prev2_q, prev2_d;
    logic               match_q, match_d;
    logic               error_q, error_d;
    logic               locked_q, locked_d;
    logic               wrap_q, wrap_d;
    logic [WIDTH-1:0]   expected_q, expected_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH:0]     sum;
    logic [CNT_W-1:0]   count_inc;

    always_comb begin
        sum       = {1'b0, prev1_q} + {1'b0, prev2_q};
        count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);

        state_d  = state_q;
        prev1_d  = prev1_q;
        prev2_d  = prev2_q;
        match_d  = 1'b0;
        error_d  = error_q;
        wrap_d   = wrap_q;
        count_d  = count_q;

        if (clear) begin
            state_d = S_IDLE;
            prev1_d = '0;
            prev2_d = '0;
            error_d = 1'b0;
            wrap_d  = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (SEED_CHECK != 0 && in_data != '0) begin
                            state_d = S_FAIL;
                            error_d = 1'b1;
                        end else begin
                            prev1_d = in_data;
                            count_d = count_inc;
                            state_d = S_ONE;
                        end
                    end
                end
                S_ONE: begin
                    if (in_valid) begin
                        if (SEED_CHECK != 0 && in_data != WIDTH'(1)) begin
                            state_d = S_FAIL;
                            error_d = 1'b1;
                        end else begin
                            prev2_d = prev1_q;
                            prev1_d = in_data;
                            count_d = count_inc;
                            state_d = S_TRACK;
                        end
                    end
                end
                S_TRACK: begin
                    // A mismatch freezes the history so the failing context stays visible.
                    if (in_valid) begin
                        if (in_data == sum[WIDTH-1:0]) begin
                            match_d = 1'b1;
                            prev2_d = prev1_q;
                            prev1_d = in_data;
                            count_d = count_inc;
                            wrap_d  = wrap_q | sum[WIDTH];
                        end else begin
                            state_d = S_FAIL;
                            error_d = 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        locked_d   = (state_d == S_TRACK);
        expected_d = prev1_d + prev2_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            prev1_q    <= '0;
            prev2_q    <= '0;
            match_q    <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
            wrap_q     <= 1'b0;
            expected_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            prev1_q    <= prev1_d;
            prev2_q    <= prev2_d;
            match_q    <= match_d;
            error_q    <= error_d;
            locked_q   <= locked_d;
            wrap_q     <= wrap_d;
            expected_q <= expected_d;
            count_q    <= count_d;
        end
    end

    assign match      = match_q;
    assign error      = error_q;
    assign locked     = locked_q;
    assign wrap_seen  = wrap_q;
    assign expected   = expected_q;
    assign term_count = count_q;

endmodule
